// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 systolic array and its result drain.
package systolic_pkg;

  localparam int ROWS_DEF = 3;
  localparam int COLS_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  function automatic int acc_w(input int datawidth);
    return 2 * datawidth + 1;
  endfunction

endpackage

// File: rtl/drain_snapshot_buf.sv
// N x AW snapshot register bank: parallel load of all accumulators, one indexed read port.
module drain_snapshot_buf #(
  parameter int AW = 17,
  parameter int N  = 9,
  parameter int IW = 4
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            load_i,
  input  logic [N*AW-1:0] wr_data_i,
  input  logic [IW-1:0]   rd_idx_i,
  output logic [AW-1:0]   rd_data_o
);

  logic [AW-1:0] mem_q [N];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (load_i) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= wr_data_i[i*AW +: AW];
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (32'(rd_idx_i) < N) rd_data_o = mem_q[rd_idx_i];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the PE accumulators on done and streams them row-major over valid/ready.
// Optional: DRAIN_PARITY_EN adds out_parity (XOR reduction of out_data).
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter  int DATAWIDTH = 8,
  parameter  int ROWS      = ROWS_DEF,
  parameter  int COLS      = COLS_DEF,
  localparam int AW        = acc_w(DATAWIDTH),
  localparam int N         = ROWS * COLS,
  localparam int IW        = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [N*AW-1:0] pe_acc,
  input  logic            done,
  input  logic            out_ready,
  input  logic            clr_overrun,
  output logic            out_valid,
  output logic [AW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            overrun
`ifdef DRAIN_PARITY_EN
  ,
  output logic            out_parity
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  drain_state_t  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] data_q, data_d, rd_data;
  logic          ovr_q, ovr_d;
  logic          load, ovr_set, xfer, at_last;

  assign xfer    = (state_q == DRAIN) && out_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (done) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (at_last) begin
            idx_d = '0;
            if (done) load = 1'b1;
            else      state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Element 0 comes straight from pe_acc on capture since the bank loads on the same edge.
  always_comb begin
    data_d = data_q;
    if (load)                data_d = pe_acc[AW-1:0];
    else if (xfer && !at_last) data_d = rd_data;
  end

  assign ovr_set = done && (state_q == DRAIN) && !load;

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set)          ovr_d = 1'b1;
    else if (clr_overrun) ovr_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  drain_snapshot_buf #(
    .AW (AW),
    .N  (N),
    .IW (IW)
  ) u_buf (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .load_i    (load),
    .wr_data_i (pe_acc),
    .rd_idx_i  (idx_d),
    .rd_data_o (rd_data)
  );

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_last  = out_valid && at_last;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign overrun   = ovr_q;
`ifdef DRAIN_PARITY_EN
  assign out_parity = ^data_q;
`endif

endmodule
